// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel slew-limited ramps.
// state | meaning: IDLE centred, MOVE ramp to target, HOLD dwell at target, RETURN ramp to centre
module servo_pwm_multi #(
  parameter int NCH          = 2,
  parameter int CW           = 20,
  parameter int PERIOD_CNT   = 540000,
  parameter int DUTY_CENTRAL = 40500,
  parameter int DUTY_OFFSET  = 18000,
  parameter int DUTY_MIN     = 13500,
  parameter int DUTY_MAX     = 67500,
  parameter int STEP         = 1800,
  parameter int HOLD_PERIODS = 150,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           cmd_valid_i,
  output logic           cmd_ready_o,
  input  logic [CHW-1:0] cmd_ch_i,
  input  logic [1:0]     cmd_dir_i,
  output logic           cmd_err_o,
  output logic [NCH-1:0] pwm_o,
  output logic [NCH-1:0] busy_o,
  output logic           frame_tick_o
);
  typedef enum logic [1:0] {IDLE, MOVE, HOLD, RETURN} state_t;

  function automatic int clamp_duty(input int v);
    if (v < DUTY_MIN) return DUTY_MIN;
    if (v > DUTY_MAX) return DUTY_MAX;
    return v;
  endfunction

  // Signed int arithmetic so an offset larger than CENTRAL clamps to MIN instead of wrapping
  localparam int            HW        = $clog2(HOLD_PERIODS + 1);
  localparam logic [CW-1:0] CENT_RST  = CW'(DUTY_CENTRAL);
  localparam logic [CW-1:0] CENT      = CW'(clamp_duty(DUTY_CENTRAL));
  localparam logic [CW-1:0] TGT_L     = CW'(clamp_duty(DUTY_CENTRAL - DUTY_OFFSET));
  localparam logic [CW-1:0] TGT_R     = CW'(clamp_duty(DUTY_CENTRAL + DUTY_OFFSET));
  localparam logic [CW-1:0] STEP_V    = CW'(STEP);
  localparam logic [CW-1:0] PER_V     = CW'(PERIOD_CNT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

  logic [CW-1:0] cnt;
  state_t        state    [NCH];
  logic [CW-1:0] duty     [NCH];
  logic [CW-1:0] duty_act [NCH];
  logic [CW-1:0] target   [NCH];
  logic [CW-1:0] duty_nxt [NCH];
  logic [HW-1:0] hold_cnt [NCH];
  logic          ch_ok;
  logic          dir_ok;
  logic          acc;
  logic [CW-1:0] dir_tgt;

  assign frame_tick_o = (cnt == PER_V);
  assign ch_ok        = (32'(cmd_ch_i) < 32'(NCH));
  assign dir_ok       = (cmd_dir_i != 2'b11);
  assign acc          = cmd_valid_i && cmd_ready_o;

  always_comb begin
    cmd_ready_o = 1'b1;
    for (int c = 0; c < NCH; c++)
      if (32'(cmd_ch_i) == 32'(c))
        cmd_ready_o = (state[c] == IDLE) || (state[c] == HOLD);
  end

  always_comb begin
    case (cmd_dir_i)
      2'b01:   dir_tgt = TGT_L;
      2'b10:   dir_tgt = TGT_R;
      default: dir_tgt = CENT;
    endcase
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      duty_nxt[c] = duty[c];
      if (state[c] == MOVE || state[c] == RETURN) begin
        if (target[c] > duty[c])
          duty_nxt[c] = (target[c] - duty[c] <= STEP_V) ? target[c] : duty[c] + STEP_V;
        else
          duty_nxt[c] = (duty[c] - target[c] <= STEP_V) ? target[c] : duty[c] - STEP_V;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt       <= '0;
      cmd_err_o <= 1'b0;
      pwm_o     <= '0;
      busy_o    <= '0;
      for (int c = 0; c < NCH; c++) begin
        state[c]    <= IDLE;
        duty[c]     <= CENT_RST;
        duty_act[c] <= CENT_RST;
        target[c]   <= CENT;
        hold_cnt[c] <= '0;
      end
    end else begin
      cnt       <= frame_tick_o ? CW'(1) : cnt + 1'b1;
      cmd_err_o <= acc && !(ch_ok && dir_ok);
      for (int c = 0; c < NCH; c++) begin
        pwm_o[c] <= (cnt != '0) && (cnt <= duty_act[c]);
        if (acc && ch_ok && dir_ok && 32'(cmd_ch_i) == 32'(c)) begin
          // An accept on the tick edge only retargets; the first step waits for the next tick
          target[c]   <= dir_tgt;
          hold_cnt[c] <= '0;
          state[c]    <= MOVE;
          busy_o[c]   <= 1'b1;
          if (frame_tick_o) duty_act[c] <= duty[c];
        end else if (frame_tick_o) begin
          duty[c]     <= duty_nxt[c];
          duty_act[c] <= duty_nxt[c];
          case (state[c])
            MOVE:
              if (duty_nxt[c] == target[c]) state[c] <= HOLD;
            RETURN:
              if (duty_nxt[c] == target[c]) begin
                state[c]  <= IDLE;
                busy_o[c] <= 1'b0;
              end
            HOLD:
              if (hold_cnt[c] == HOLD_LAST) begin
                target[c] <= CENT;
                state[c]  <= RETURN;
              end else begin
                hold_cnt[c] <= hold_cnt[c] + 1'b1;
              end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: per-frame pulse widths are checked against a queue of expected widths.
module tb_servo_pwm_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid, ready, err, tick;
  logic [0:0] ch;
  logic [1:0] dir;
  logic [1:0] pwm, busy;
  logic       valid2, ready2, err2, tick2;
  logic [1:0] ch2, dir2;
  logic [2:0] pwm2, busy2;

  int n_vec = 0;
  int n_err = 0;
  int exp_q [5][$];

  localparam int S_LEFT  [10] = '{50, 42, 34, 30, 30, 30, 30, 38, 46, 50};
  localparam int S_MOVE  [3]  = '{50, 42, 34};
  localparam int S_RIGHT [12] = '{30, 38, 46, 54, 62, 70, 70, 70, 70, 62, 54, 50};
  localparam int S_COIN  [8]  = '{50, 42, 34, 30, 30, 30, 30, 38};
  localparam int S_CLAMP [12] = '{50, 42, 34, 26, 20, 20, 20, 20, 28, 36, 44, 50};

  always #5 clk = ~clk;

  servo_pwm_multi #(.NCH(2), .CW(20), .PERIOD_CNT(100), .DUTY_CENTRAL(50), .DUTY_OFFSET(20),
                    .DUTY_MIN(20), .DUTY_MAX(80), .STEP(8), .HOLD_PERIODS(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(valid), .cmd_ready_o(ready), .cmd_ch_i(ch),
    .cmd_dir_i(dir), .cmd_err_o(err), .pwm_o(pwm), .busy_o(busy), .frame_tick_o(tick));

  // Three channels (so channel 3 is out of range) and an offset large enough to hit the lower clamp
  servo_pwm_multi #(.NCH(3), .CW(20), .PERIOD_CNT(100), .DUTY_CENTRAL(50), .DUTY_OFFSET(40),
                    .DUTY_MIN(20), .DUTY_MAX(80), .STEP(8), .HOLD_PERIODS(3)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(valid2), .cmd_ready_o(ready2), .cmd_ch_i(ch2),
    .cmd_dir_i(dir2), .cmd_err_o(err2), .pwm_o(pwm2), .busy_o(busy2), .frame_tick_o(tick2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Width of each frame's pulse, compared when the frame ends; idle channels expect centre (50)
  logic [4:0] pwm_all;
  assign pwm_all = {pwm2, pwm};
  int  w [5];
  int  since;
  bit  have_prev;
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) w[i] = 0;
      since = 0;
      have_prev = 0;
    end else begin
      since++;
      for (int i = 0; i < 5; i++) if (pwm_all[i]) w[i]++;
      if (tick) begin
        if (have_prev) check("frame_period", since, 100);
        have_prev = 1;
        since = 0;
        for (int i = 0; i < 5; i++) begin
          if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
          else e = 50;
          check($sformatf("width_ch%0d", i), w[i], e);
          w[i] = 0;
        end
      end
    end
  end

  task automatic wait_negs(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (tick) got = 1;
    end
    check("tick_timeout", got, 1);
  endtask

  task automatic wait_empty(input int i);
    for (int k = 0; k < 2000 && exp_q[i].size() > 0; k++) @(negedge clk);
    check("drain_timeout", exp_q[i].size(), 0);
  endtask

  // Called at a negedge; drives one command and returns 1 time unit after the accepting edge
  task automatic send(input bit sel, input int c, input logic [1:0] d);
    if (!sel) begin
      valid = 1'b1; ch = 1'(c); dir = d;
      #1 check("ready", ready, 1);
    end else begin
      valid2 = 1'b1; ch2 = 2'(c); dir2 = d;
      #1 check("ready2", ready2, 1);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    valid2 = 1'b0;
  endtask

  initial begin
    bit got;
    valid = 0; ch = 0; dir = 0; valid2 = 0; ch2 = 0; dir2 = 0;
    wait_negs(5);
    check("reset_pwm", pwm, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_tick", tick, 0);
    rst_n = 1'b1;
    wait_tick(); wait_tick(); wait_tick();
    check("idle_busy", busy, 0);
    check("idle_busy2", busy2, 0);

    // LEFT on ch0: ramp, hold, return to centre
    wait_tick(); wait_negs(10);
    send(0, 0, 2'b01);
    for (int k = 0; k < 10; k++) exp_q[0].push_back(S_LEFT[k]);
    check("left_busy", busy, 2'b01);
    check("left_err", err, 0);
    wait_empty(0);
    check("left_done_busy", busy, 0);

    // Command stalled during MOVE, then RIGHT accepted in HOLD
    wait_tick(); wait_negs(10);
    send(0, 0, 2'b01);
    for (int k = 0; k < 3; k++) exp_q[0].push_back(S_MOVE[k]);
    valid = 1'b1; ch = 1'b0; dir = 2'b10;
    @(negedge clk);
    check("stall_move", ready, 0);
    wait_tick();
    check("stall_t1", ready, 0);
    wait_tick();
    check("stall_t2", ready, 0);
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (ready) got = 1;
    end
    check("ready_in_hold", got, 1);
    @(posedge clk);
    #1 valid = 1'b0;
    for (int k = 0; k < 12; k++) exp_q[0].push_back(S_RIGHT[k]);
    check("right_busy", busy, 2'b01);
    wait_empty(0);
    check("right_done_busy", busy, 0);

    // Reserved direction and out-of-range channel
    wait_negs(3);
    send(0, 1, 2'b11);
    check("bad_dir_err", err, 1);
    check("bad_dir_busy", busy, 0);
    @(posedge clk);
    #1 check("bad_dir_err_clr", err, 0);
    @(negedge clk);
    send(1, 3, 2'b01);
    check("bad_ch_err", err2, 1);
    check("bad_ch_busy", busy2, 0);
    @(posedge clk);
    #1 check("bad_ch_err_clr", err2, 0);

    // Accept on the tick edge, then reset in the middle of RETURN
    wait_tick();
    send(0, 0, 2'b01);
    check("coin_busy", busy, 2'b01);
    for (int k = 0; k < 8; k++) exp_q[0].push_back(S_COIN[k]);
    wait_empty(0);
    wait_negs(20);
    check("pre_rst_busy", busy, 2'b01);
    rst_n = 1'b0;
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_busy", busy, 0);
    wait_negs(3);
    rst_n = 1'b1;
    wait_tick(); wait_tick(); wait_tick();
    check("post_rst_busy", busy, 0);

    // Clamped LEFT target on the three-channel instance
    wait_tick(); wait_negs(10);
    send(1, 2, 2'b01);
    check("clamp_busy", busy2, 3'b100);
    for (int k = 0; k < 12; k++) exp_q[4].push_back(S_CLAMP[k]);
    wait_empty(4);
    check("clamp_done_busy", busy2, 0);
    wait_tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
